// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Registered program counter for the fetch stage. Each advancing cycle the PC
// steps by STEP (modulo 2^PC_W). Stall holds it, and a redirect loads a
// branch/jump target. An optional return-address stack (RAS) serves
// call/return.
//
// Build option:
//   PC_FETCH_RAS_EN  defined   -> RAS storage built (RAS_DEPTH entries)
//                    undefined -> no RAS. call is ignored, ret never pops,
//                                 ras_empty=1, ras_full=0, ras_ovf=0
//
// Parameters:
//   PC_W       PC / address width (2..32)
//   STEP       increment per advancing cycle (1..2^PC_W-1)
//   RESET_PC   PC value loaded on reset
//   RAS_DEPTH  RAS entries, power of two, >= 2 (RAS builds only)
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   stall          hold PC and RAS this cycle
//   redirect_valid load redirect_pc (branch taken / jump / call)
//   redirect_pc    redirect target
//   call           marks the redirect as a call and pushes the return address
//   ret            return, taking its target from the RAS top (falls back to
//                  redirect_pc when the RAS is empty)
//   pc             current PC (registered)
//   pc_inc         pc + STEP (combinational)
//   pc_valid       pc holds a fetchable address
//   ras_empty      RAS holds no entries
//   ras_full       RAS holds RAS_DEPTH entries
//   ras_ovf        sticky flag, set when a push overwrote the oldest entry
//
// State | meaning
// ------+--------------------------------------------------------------
// S_WAIT| out of reset; first edge only raises pc_valid, pc stays put
// S_RUN | normal fetch; stall / ret / redirect / increment each edge
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int unsigned PC_W      = 7,
  parameter int unsigned STEP      = 1,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            call,
  input  logic            ret,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_inc,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf
);

  localparam logic [PC_W-1:0] STEP_V  = PC_W'(STEP);
  localparam logic [PC_W-1:0] RESET_V = PC_W'(RESET_PC);

  typedef enum logic {
    S_WAIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc_next;

  // Natural wrap of the PC_W-bit adder gives the modulo 2^PC_W behaviour.
  assign pc_inc = pc + STEP_V;

`ifdef PC_FETCH_RAS_EN

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  // wr_ptr points at the slot the next push writes; the top is wr_ptr-1.
  // With a power-of-two depth the pointer wraps on its own, so a push while
  // full lands on the oldest entry.
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] ras_cnt;
  logic             ovf_q;
  logic [PTR_W-1:0] top_ptr;
  logic             do_push;
  logic             do_pop;

  assign top_ptr   = wr_ptr - PTR_W'(1);
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == DEPTH_V);
  assign ras_ovf   = ovf_q;

  always_comb begin
    pc_next = pc_inc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (ret && !ras_empty) begin
      pc_next = ras_mem[top_ptr];
      do_pop  = 1'b1;
    end else if (ret) begin
      // Empty RAS: act like an ordinary jump or fall-through, and never pop.
      pc_next = redirect_valid ? redirect_pc : pc_inc;
    end else if (redirect_valid) begin
      pc_next = redirect_pc;
      do_push = call;
    end
  end

  // Entry storage needs no reset; ras_cnt alone says which entries are live.
  always_ff @(posedge clk) begin
    if (state == S_RUN && !stall && do_push) begin
      ras_mem[wr_ptr] <= pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      ras_cnt <= '0;
      ovf_q   <= 1'b0;
    end else if (state == S_RUN && !stall) begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (ras_cnt == DEPTH_V) begin
          ovf_q <= 1'b1;
        end else begin
          ras_cnt <= ras_cnt + CNT_W'(1);
        end
      end else if (do_pop) begin
        wr_ptr  <= top_ptr;
        ras_cnt <= ras_cnt - CNT_W'(1);
      end
    end
  end

`else

  // Without a RAS, call has no effect and ret reduces to a jump/increment.
  logic unused_cfg;
  assign unused_cfg = &{1'b0, call, 1'(RAS_DEPTH)};

  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;

  always_comb begin
    pc_next = pc_inc;
    if (ret) begin
      pc_next = redirect_valid ? redirect_pc : pc_inc;
    end else if (redirect_valid) begin
      pc_next = redirect_pc;
    end
  end

`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_WAIT;
      pc       <= RESET_V;
      pc_valid <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          // Control inputs are ignored on this edge; pc stays at RESET_PC.
          state    <= S_RUN;
          pc_valid <= 1'b1;
        end
        S_RUN: begin
          if (!stall) begin
            pc <= pc_next;
          end
        end
        default: begin
          state    <= S_WAIT;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam int PC_W      = 7;
  localparam int STEP      = 1;
  localparam int RESET_PC  = 0;
  localparam int RAS_DEPTH = 4;
  localparam int MOD       = 1 << PC_W;
`ifdef PC_FETCH_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic            call = 1'b0;
  logic            ret = 1'b0;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic            pc_valid;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_ovf;

  int tests = 0;
  int fails = 0;

  pc_fetch_unit #(
    .PC_W(PC_W), .STEP(STEP), .RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .call(call), .ret(ret), .pc(pc), .pc_inc(pc_inc), .pc_valid(pc_valid),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: PC as an integer, RAS as a queue of return addresses.
  int m_pc    = RESET_PC;
  bit m_valid = 1'b0;
  bit m_ovf   = 1'b0;
  int m_ras[$];

  function automatic int inc_of(input int v);
    return (v + STEP) % MOD;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc    = RESET_PC;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_ras.delete();
    end else if (!m_valid) begin
      m_valid = 1'b1;
    end else if (!stall) begin
      if (ret && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
      end else if (ret || !redirect_valid) begin
        m_pc = (ret && redirect_valid) ? int'(redirect_pc) : inc_of(m_pc);
      end else begin
        if (call && RAS_ON) begin
          if (m_ras.size() == RAS_DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_ras.push_back(inc_of(m_pc));
        end
        m_pc = int'(redirect_pc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("pc", 32'(pc), 32'(m_pc));
    chk("pc_inc", 32'(pc_inc), 32'(inc_of(m_pc)));
    chk("pc_valid", 32'(pc_valid), 32'(m_valid));
    chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    chk("ras_full", 32'(ras_full), 32'(m_ras.size() == RAS_DEPTH));
    chk("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
  end

  // Apply one cycle of inputs (set right after a falling edge) and return
  // at the next falling edge, when the edge's result is visible.
  task automatic cyc(input bit s, input bit rv, input int rpc, input bit c, input bit r);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = PC_W'(rpc);
    call           = c;
    ret            = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_valid", 32'(pc_valid), 0);
    chk("rst_empty", 32'(ras_empty), 1);

    rst_n = 1'b1;
    // First edge: pc_valid rises, pc stays at RESET_PC, redirect ignored.
    cyc(0, 1, 99, 0, 0);
    chk("edge1_valid", 32'(pc_valid), 1);
    chk("edge1_pc", 32'(pc), 0);
    idle(1);
    chk("run_pc1", 32'(pc), 1);
    idle(2);
    chk("run_pc3", 32'(pc), 3);
    idle(2);
    chk("run_pc5", 32'(pc), 5);

    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 77, 0, 1);
      chk("stall_hold", 32'(pc), 5);
    end
    cyc(0, 1, 40, 0, 0);
    chk("redir_40", 32'(pc), 40);
    idle(1);
    chk("redir_41", 32'(pc), 41);

    cyc(0, 1, 126, 0, 0);
    idle(1);
    chk("wrap_pc127", 32'(pc), 127);
    chk("wrap_inc0", 32'(pc_inc), 0);
    idle(1);
    chk("wrap_pc0", 32'(pc), 0);

    // Call without redirect_valid: no push, plain increment.
    cyc(0, 0, 90, 1, 0);
    chk("call_norv_pc", 32'(pc), 1);
    chk("call_norv_empty", 32'(ras_empty), 1);

    cyc(0, 1, 10, 0, 0);
`ifdef PC_FETCH_RAS_EN
    cyc(0, 1, 60, 1, 0);
    chk("call_pc60", 32'(pc), 60);
    chk("call_nonempty", 32'(ras_empty), 0);
    idle(2);
    chk("adv_pc62", 32'(pc), 62);
    cyc(0, 1, 99, 1, 1);
    chk("ret_pc11", 32'(pc), 11);
    chk("ret_empty", 32'(ras_empty), 1);

    cyc(0, 1, 1, 0, 0);
    for (int i = 1; i <= 5; i++) cyc(0, 1, (i == 5) ? 100 : i + 1, 1, 0);
    chk("ovf_full", 32'(ras_full), 1);
    chk("ovf_flag", 32'(ras_ovf), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk("ret_chain", 32'(pc), 32'(6 - i));
    end
    chk("chain_empty", 32'(ras_empty), 1);
    cyc(0, 0, 0, 0, 1);
    chk("ret_empty_inc", 32'(pc), 4);
    cyc(0, 1, 70, 0, 1);
    chk("ret_empty_redir", 32'(pc), 70);
    chk("ovf_sticky", 32'(ras_ovf), 1);

    cyc(0, 1, 20, 0, 0);
    cyc(0, 1, 30, 1, 0);
    cyc(0, 1, 31, 1, 0);
    idle(2);
`else
    cyc(0, 1, 60, 1, 0);
    chk("nor_call_pc60", 32'(pc), 60);
    cyc(0, 0, 0, 0, 1);
    chk("nor_ret_pc61", 32'(pc), 61);
    chk("nor_empty", 32'(ras_empty), 1);
    cyc(0, 1, 33, 0, 0);
`endif
    chk("pre_rst_pc33", 32'(pc), 33);
    #1 rst_n = 1'b0;
    #1;
    chk("async_pc", 32'(pc), 0);
    chk("async_valid", 32'(pc_valid), 0);
    chk("async_empty", 32'(ras_empty), 1);
    chk("async_ovf", 32'(ras_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 50, 0, 0);
    chk("rerun_pc0", 32'(pc), 0);
    chk("rerun_valid", 32'(pc_valid), 1);
    cyc(0, 1, 50, 0, 0);
    chk("rerun_pc50", 32'(pc), 50);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter unit for the fetch stage of the pipeline. It generalises the fixed 7-bit combinational incrementer into a registered PC. It adds a configurable width and step, stall hold, and branch/jump redirect. An optional return-address stack (RAS) handles call/return. It drives the instruction-memory address and supplies the incremented PC to the decode stage.

## Interface
Parameters:
- PC_W, 7, PC and address width in bits (2..32)
- STEP, 1, increment added each advancing cycle (1..2^PC_W-1)
- RESET_PC, 0, PC value loaded on reset
- RAS_DEPTH, 4, RAS entries, power of two, ≥2 (used only with RAS_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and RAS this cycle
- redirect_valid  in  1  load redirect_pc (branch taken / jump / call)
- redirect_pc  in  PC_W  redirect target
- call  in  1  qualifies redirect as call: push return address
- ret  in  1  return: target from RAS top (fallback redirect_pc)
- pc  out  PC_W  current PC, registered
- pc_inc  out  PC_W  (pc + STEP) mod 2^PC_W, combinational from pc
- pc_valid  out  1  PC holds a fetchable address
- ras_empty  out  1  RAS holds no entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_ovf  out  1  sticky: a push overwrote an entry

## Operation
- Reset (rst_n=0, async): pc=RESET_PC, pc_valid=0, RAS cleared, ras_empty=1, ras_full=0, ras_ovf=0.
- First rising edge after release: pc_valid←1. pc holds RESET_PC and does not advance.
- Every later edge, first matching case applies:
  1. stall=1: pc, RAS and flags all hold.
  2. ret=1, RAS non-empty: pc←top, pop; call ignored.
  3. ret=1, RAS empty: pc←redirect_pc if redirect_valid, else pc←pc_inc. No pop.
  4. redirect_valid=1: pc←redirect_pc. If call=1, push pc_inc (address of the instruction after the call).
  5. Otherwise: pc←pc_inc.
- call without redirect_valid is ignored (no push).
- Arithmetic is modulo 2^PC_W. With STEP=1, PC_W=7, pc=127 gives pc_inc=0. No carry out.
- RAS is circular with pointer and count. A push when full overwrites the oldest entry: count stays RAS_DEPTH and ras_ovf←1 until reset. A pop when empty cannot occur (case 3).
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH). Both are registered-state derived.

## Timing
- pc: one-cycle latency from redirect/ret/increment decision to new value.
- pc_inc: zero latency from pc, combinational.
- Push and pop complete at the same edge as the pc update. A ret on the next cycle sees the pushed entry.
- Inputs are sampled only at rising edges with pc_valid=1. While pc_valid=0, stall, redirect_valid, call and ret are ignored.
- A reset assertion mid-operation takes effect immediately, without waiting for a clock edge. All state returns to its reset values.

## Configuration
- Macro PC_FETCH_RAS_EN.
- Defined: the RAS is built as described.
- Undefined: no RAS storage is built.
  - call is ignored; redirect behaves as plain jump.
  - ret follows case 3 always.
  - ras_empty tied 1, ras_full tied 0, ras_ovf tied 0.
  - RAS_DEPTH is unused.

## Test plan
- Reset then free run, PC_W=7, STEP=1, RESET_PC=0 -> pc_valid rises at edge 1 with pc=0, then pc goes 1, 2, 3…. From pc=127, next pc=0 and pc_inc at 127 reads 0.
- At pc=5: stall=1 for 3 cycles, then redirect_valid=1, redirect_pc=40 -> pc holds 5 for 3 cycles, then 40, then 41.
- RAS_EN: at pc=10, call with redirect_pc=60 -> pc=60, RAS top=11. Advance to 62, then ret -> pc=11, ras_empty=1.
- RAS_EN, RAS_DEPTH=4: five calls from pcs 1, 2, 3, 4, 5 -> ras_full=1, ras_ovf=1. Four rets return 6, 5, 4, 3, then ras_empty=1. A fifth ret with redirect_valid=0 goes to pc_inc.
- Assert rst_n low mid-run at pc=33 with 2 RAS entries -> pc=RESET_PC and pc_valid=0 immediately, without a clock edge. ras_empty=1, ras_ovf=0.
- Without macro: call at pc=10 to 60, then ret with redirect_valid=0 -> pc=60, then pc=61. ras_empty stays 1.
